// File: rtl/huffman_gen.sv
// Histograms symbols 1..NSYM, then builds a deterministic Huffman code per symbol.
// Optional build macro HUFF_ZERO_EXCLUDE_EN drops zero-count symbols from the tree.
module huffman_gen #(
  parameter int NSYM = 6,
  parameter int CW   = 8,
  parameter int LW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gray_valid,
  input  logic [7:0]           gray_data,
  output logic                 CNT_valid,
  output logic [NSYM*CW-1:0]   cnt,
  output logic                 code_valid,
  output logic [NSYM*LW-1:0]   hc,
  output logic [NSYM*LW-1:0]   m
);

  localparam int NN  = 2*NSYM - 1;
  localparam int IW  = $clog2(NN);
  localparam int WW  = CW + 3;
  localparam int LNW = $clog2(LW + 1);

  typedef enum logic [1:0] {COUNT, REPORT, BUILD, DONE} state_e;
  state_e state_q, state_d;

  logic [CW-1:0]   cnt_q  [NSYM];
  logic [WW-1:0]   w_q    [NN];
  logic [NSYM-1:0] mem_q  [NN];
  logic [NN-1:0]   act_q;
  logic [LW-1:0]   code_q [NSYM];
  logic [LNW-1:0]  len_q  [NSYM];
  logic [IW-1:0]   k_q, nm_q;

  logic            in_range, seen, lo_found, sec_found;
  logic [NSYM-1:0] leaf_act;
  logic [IW-1:0]   nz, lo_id, sec_id, new_id;
  logic [WW-1:0]   lo_w, sec_w;

  assign in_range = (gray_data != 8'd0) && (gray_data <= 8'(NSYM));
  assign new_id   = IW'(NSYM) + k_q;

  always_comb begin
    seen = 1'b0;
    nz   = '0;
    for (int unsigned i = 0; i < NSYM; i++) begin
      if (cnt_q[i] != '0) seen = 1'b1;
`ifdef HUFF_ZERO_EXCLUDE_EN
      leaf_act[i] = (cnt_q[i] != '0);
`else
      leaf_act[i] = 1'b1;
`endif
      if (leaf_act[i]) nz = nz + IW'(1);
    end
  end

  // Ascending scan with <= lets the larger id win ties, i.e. rank lower.
  always_comb begin
    lo_found  = 1'b0;
    lo_id     = '0;
    lo_w      = '0;
    sec_found = 1'b0;
    sec_id    = '0;
    sec_w     = '0;
    for (int unsigned i = 0; i < NN; i++) begin
      if (act_q[i] && (!lo_found || w_q[i] <= lo_w)) begin
        lo_found = 1'b1;
        lo_id    = IW'(i);
        lo_w     = w_q[i];
      end
    end
    for (int unsigned i = 0; i < NN; i++) begin
      if (act_q[i] && (IW'(i) != lo_id) && (!sec_found || w_q[i] <= sec_w)) begin
        sec_found = 1'b1;
        sec_id    = IW'(i);
        sec_w     = w_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COUNT:  if (!gray_valid && seen) state_d = REPORT;
      REPORT: state_d = (nz <= IW'(1)) ? DONE : BUILD;
      BUILD:  if (k_q == nm_q - IW'(1)) state_d = DONE;
      DONE:   if (gray_valid && in_range) state_d = COUNT;
      default: state_d = COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= COUNT;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSYM; i++) begin
        cnt_q[i]  <= '0;
        code_q[i] <= '0;
        len_q[i]  <= '0;
      end
      for (int unsigned n = 0; n < NN; n++) begin
        w_q[n]   <= '0;
        mem_q[n] <= '0;
      end
      act_q <= '0;
      k_q   <= '0;
      nm_q  <= '0;
    end else begin
      case (state_q)
        COUNT: begin
          if (gray_valid && in_range)
            for (int unsigned i = 0; i < NSYM; i++)
              if (gray_data == 8'(i + 1) && cnt_q[i] != '1)
                cnt_q[i] <= cnt_q[i] + CW'(1);
        end
        REPORT: begin
          for (int unsigned i = 0; i < NSYM; i++) begin
            w_q[i]    <= WW'(cnt_q[i]);
            mem_q[i]  <= NSYM'(1) << i;
            code_q[i] <= '0;
            len_q[i]  <= '0;
          end
          for (int unsigned n = NSYM; n < NN; n++) begin
            w_q[n]   <= '0;
            mem_q[n] <= '0;
          end
          act_q <= NN'(leaf_act);
          k_q   <= '0;
          nm_q  <= nz - IW'(1);
`ifdef HUFF_ZERO_EXCLUDE_EN
          if (nz == IW'(1))
            for (int unsigned i = 0; i < NSYM; i++)
              if (leaf_act[i]) len_q[i] <= LNW'(1);
`endif
        end
        BUILD: begin
          // Codes start cleared, so only the '1' bits need writing.
          for (int unsigned j = 0; j < NSYM; j++) begin
            if (mem_q[lo_id][j]) begin
              code_q[j] <= code_q[j] | (LW'(1) << len_q[j]);
              len_q[j]  <= len_q[j] + LNW'(1);
            end else if (mem_q[sec_id][j]) begin
              len_q[j]  <= len_q[j] + LNW'(1);
            end
          end
          act_q[lo_id]   <= 1'b0;
          act_q[sec_id]  <= 1'b0;
          act_q[new_id]  <= 1'b1;
          w_q[new_id]    <= lo_w + sec_w;
          mem_q[new_id]  <= mem_q[lo_id] | mem_q[sec_id];
          k_q            <= k_q + IW'(1);
        end
        DONE: begin
          if (gray_valid && in_range) begin
            for (int unsigned i = 0; i < NSYM; i++) begin
              cnt_q[i]  <= (gray_data == 8'(i + 1)) ? CW'(1) : '0;
              code_q[i] <= '0;
              len_q[i]  <= '0;
            end
            act_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt        = '0;
    hc         = '0;
    m          = '0;
    CNT_valid  = (state_q == REPORT);
    code_valid = (state_q == DONE);
    for (int unsigned i = 0; i < NSYM; i++) begin
      cnt[i*CW +: CW] = cnt_q[i];
      if (state_q == DONE) begin
        hc[i*LW +: LW] = code_q[i];
        for (int unsigned b = 0; b < LW; b++)
          m[i*LW + b] = (32'(len_q[i]) > b);
      end
    end
  end

endmodule
